dma_desc_frontend: RTL and testbench
====================================

Name: dma_desc_frontend

Overview:
- Register-mapped configuration frontend for the SoC DMA engine.
- Sits behind the SDMA crossbar slave, after the AXI-to-register converter, in the 4 KiB window at 0x5000_0000.
- Software writes the source, destination and length registers, then reads NEXT_ID. That read launches one transfer descriptor to the DMA backend, which drives the MDMA master port.
- Tracks outstanding transfers, the last completed transfer ID and a completion interrupt.

Parameters:
- AddrWidth, 64, width of the source and destination addresses.
- LenWidth, 64, width of the byte count.
- IdCntWidth, 32, width of the transfer-ID counters.
- MaxOutstanding, 4, maximum number of descriptors issued but not yet completed.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- reg_valid_i  in  1  register request valid.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  12  byte offset within the window.
- reg_wdata_i  in  64  write data.
- reg_wstrb_i  in  8  byte enables.
- reg_ready_o  out  1  request accepted; response is valid this cycle.
- reg_rdata_o  out  64  read data.
- reg_error_o  out  1  access error.
- desc_valid_o  out  1  descriptor valid.
- desc_ready_i  in  1  backend accepts the descriptor.
- desc_o  out  dma_desc_t  {src, dst, num_bytes, decouple, deburst}.
- done_i  in  1  one-cycle pulse per completed transfer, in issue order.
- busy_o  out  1  a transfer is in flight or being issued.
- irq_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous): all outputs are 0. SRC, DST, NUM_BYTES and CONFIG are 0. next_id = 1, done_id = 0, outstanding = 0, FSM in IDLE.
- Register map (64-bit registers):
  - 0x00 SRC, RW.
  - 0x08 DST, RW.
  - 0x10 NUM_BYTES, RW.
  - 0x18 CONFIG, RW: bit0 decouple, bit1 deburst, other bits read 0.
  - 0x20 STATUS, RO: bit0 busy, bits[15:8] outstanding.
  - 0x28 NEXT_ID, RO with side effect.
  - 0x30 DONE_ID, RO.
- Writes are applied per byte under reg_wstrb_i.
- Error responses (ready=1, error=1, rdata=0, no state change):
  - write to a RO register;
  - unmapped offset;
  - reg_addr_i[2:0] != 0.
- FSM IDLE:
  - Every access except a NEXT_ID read completes combinationally in the same cycle (reg_ready_o = reg_valid_i).
  - NEXT_ID read with NUM_BYTES == 0: ready=1, error=1, rdata=0, nothing issued.
  - NEXT_ID read with NUM_BYTES != 0 and outstanding < MaxOutstanding: capture the descriptor from the current registers, go to ISSUE, reg_ready_o=0.
  - NEXT_ID read with outstanding == MaxOutstanding: stall with reg_ready_o=0, stay in IDLE, retry every cycle.
- FSM ISSUE:
  - desc_valid_o=1; desc_o is held stable until the handshake.
  - In the cycle desc_ready_i=1: reg_ready_o=1, reg_rdata_o = next_id (zero-extended), next_id increments, outstanding increments, return to IDLE.
  - A request that is not the stalled NEXT_ID read cannot occur (single master, request held); behaviour in that case is undefined.
- Latency: a NEXT_ID read completes at minimum 2 cycles after reg_valid_i rises (1 in IDLE, 1 in ISSUE with desc_ready_i=1).
- ID wrap: both next_id and done_id wrap from 2^IdCntWidth-1 to 1; 0 is never used as an ID. done_id holds the last completed ID.
- done_i:
  - With outstanding > 0: done_id advances by one (same wrap), outstanding decrements, irq_o=1 for the next cycle (registered).
  - With outstanding == 0: ignored, no irq_o pulse.
- A descriptor handshake and done_i in the same cycle: outstanding is unchanged; next_id and done_id both advance.
- busy_o (registered) = (outstanding != 0) || (state == ISSUE).
- Reset asserted mid-ISSUE: desc_valid_o drops immediately and the pending read is lost.

Decomposition:
- Package dma_frontend_pkg:
  - dma_desc_t (packed struct: src[AddrWidth], dst[AddrWidth], num_bytes[LenWidth], decouple, deburst);
  - register offset constants;
  - the STATUS/CONFIG bit positions;
  - fsm_state_e {IDLE, ISSUE}.
- The window base and length constants (0x5000_0000, 0x1000) remain in ariane_soc.
- One sub-module is natural: dma_id_counter, a wrapping counter that skips 0, instantiated for next_id and done_id.

Test Plan:
- Reset, then read NEXT_ID with NUM_BYTES=0 -> error=1, rdata=0, desc_valid_o never asserts, next_id stays 1.
- Write SRC=0x8000_0000, DST=0x8000_1000, NUM_BYTES=0x40, CONFIG=0x1, then read NEXT_ID with desc_ready_i held high -> ready=1 exactly 2 cycles after reg_valid_i rises, rdata=1, desc_o={0x8000_0000, 0x8000_1000, 0x40, decouple=1, deburst=0}; a second launch returns 2.
- desc_ready_i held low for 5 cycles -> desc_valid_o and desc_o stable for 5 cycles, reg_ready_o=0; on the handshake, rdata=1, STATUS outstanding=1, busy=1.
- Issue 4 descriptors, then read NEXT_ID -> stall until done_i pulses; then DONE_ID=1, irq_o pulses once, and the stalled read returns 5.
- Preload next_id = 0xFFFF_FFFF, then launch twice -> returns 0xFFFF_FFFF then 1; a done_i pulse with outstanding==0 -> DONE_ID unchanged, no irq_o; handshake and done_i in the same cycle -> outstanding unchanged.
- Write to 0x28, read 0x38, read 0x04 -> error=1 for each; reset asserted during ISSUE -> all outputs 0 immediately.

Source files
------------

// File: rtl/dma_frontend_pkg.sv
// Shared types and register map for the DMA descriptor frontend.
// Descriptor layout matches what the DMA backend consumes.
package dma_frontend_pkg;

    localparam int AddrWidth = 64;
    localparam int LenWidth  = 64;

    localparam logic [11:0] RegSrc      = 12'h000;
    localparam logic [11:0] RegDst      = 12'h008;
    localparam logic [11:0] RegNumBytes = 12'h010;
    localparam logic [11:0] RegConfig   = 12'h018;
    localparam logic [11:0] RegStatus   = 12'h020;
    localparam logic [11:0] RegNextId   = 12'h028;
    localparam logic [11:0] RegDoneId   = 12'h030;

    localparam int CfgDecoupleBit = 0;
    localparam int CfgDeburstBit  = 1;
    localparam int StatusBusyBit  = 0;
    localparam int StatusOutLsb   = 8;

    typedef struct packed {
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [LenWidth-1:0]  num_bytes;
        logic                 decouple;
        logic                 deburst;
    } dma_desc_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } fsm_state_e;

    function automatic logic [63:0] apply_strb(
        input logic [63:0] old,
        input logic [63:0] wdata,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = old;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dma_desc_frontend_id_counter.sv
// Transfer-ID counter: increments on enable and wraps to 1,
// so ID 0 stays reserved as "none".
module dma_id_counter
    import dma_frontend_pkg::*;
#(
    parameter int               Width    = 32,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= ResetVal;
        end else if (en_i) begin
            cnt_q <= (&cnt_q) ? Width'(1) : cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dma_desc_frontend.sv
// Register frontend of the DMA engine: a NEXT_ID read launches one
// descriptor and tracks outstanding transfers and completions.
module dma_desc_frontend
    import dma_frontend_pkg::*;
#(
    parameter int IdCntWidth     = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [11:0] reg_addr_i,
    input  logic [63:0] reg_wdata_i,
    input  logic [7:0]  reg_wstrb_i,
    output logic        reg_ready_o,
    output logic [63:0] reg_rdata_o,
    output logic        reg_error_o,
    output logic        desc_valid_o,
    input  logic        desc_ready_i,
    output dma_desc_t   desc_o,
    input  logic        done_i,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int OutW = $clog2(MaxOutstanding + 1);

    fsm_state_e state_q, state_d;

    logic [63:0]     src_q, dst_q, nbytes_q;
    logic [1:0]      cfg_q;
    dma_desc_t       desc_q;
    logic [OutW-1:0] out_q, out_d;
    logic            irq_q, busy_q, busy_d;

    logic [IdCntWidth-1:0] next_id, done_id;

    logic        launch, handshake, done_acc;
    logic        wr_src, wr_dst, wr_nb, wr_cfg;
    logic        ready, error;
    logic [63:0] rdata, rd_mux;
    logic        aligned, mapped, ro;

    assign aligned = reg_addr_i[2:0] == 3'b000;
    assign mapped  = reg_addr_i <= RegDoneId;
    assign ro      = reg_addr_i inside {RegStatus, RegNextId, RegDoneId};

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            RegSrc:      rd_mux = src_q;
            RegDst:      rd_mux = dst_q;
            RegNumBytes: rd_mux = nbytes_q;
            RegConfig:   rd_mux = 64'(cfg_q);
            RegStatus: begin
                rd_mux[StatusOutLsb +: 8] = 8'(out_q);
                rd_mux[StatusBusyBit]     = busy_q;
            end
            RegDoneId:   rd_mux = 64'(done_id);
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        error     = 1'b0;
        rdata     = '0;
        launch    = 1'b0;
        handshake = 1'b0;
        wr_src    = 1'b0;
        wr_dst    = 1'b0;
        wr_nb     = 1'b0;
        wr_cfg    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reg_valid_i) begin
                    if (!aligned || !mapped || (reg_write_i && ro)) begin
                        ready = 1'b1;
                        error = 1'b1;
                    end else if (reg_write_i) begin
                        ready  = 1'b1;
                        wr_src = reg_addr_i == RegSrc;
                        wr_dst = reg_addr_i == RegDst;
                        wr_nb  = reg_addr_i == RegNumBytes;
                        wr_cfg = reg_addr_i == RegConfig;
                    end else if (reg_addr_i == RegNextId) begin
                        // a full window leaves ready low so the read retries
                        if (nbytes_q == '0) begin
                            ready = 1'b1;
                            error = 1'b1;
                        end else if (out_q < OutW'(MaxOutstanding)) begin
                            launch  = 1'b1;
                            state_d = ISSUE;
                        end
                    end else begin
                        ready = 1'b1;
                        rdata = rd_mux;
                    end
                end
            end
            ISSUE: begin
                if (desc_ready_i) begin
                    handshake = 1'b1;
                    ready     = 1'b1;
                    rdata     = 64'(next_id);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_acc = done_i && (out_q != '0);

    always_comb begin
        out_d = out_q;
        case ({handshake, done_acc})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase
    end

    assign busy_d = (out_d != '0) || (state_d == ISSUE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            nbytes_q <= '0;
            cfg_q    <= '0;
            desc_q   <= '0;
            out_q    <= '0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            irq_q   <= done_acc;
            busy_q  <= busy_d;
            if (wr_src) src_q <= apply_strb(src_q, reg_wdata_i, reg_wstrb_i);
            if (wr_dst) dst_q <= apply_strb(dst_q, reg_wdata_i, reg_wstrb_i);
            if (wr_nb) nbytes_q <= apply_strb(nbytes_q, reg_wdata_i, reg_wstrb_i);
            if (wr_cfg && reg_wstrb_i[0]) cfg_q <= reg_wdata_i[1:0];
            if (launch) begin
                desc_q.src       <= src_q;
                desc_q.dst       <= dst_q;
                desc_q.num_bytes <= nbytes_q;
                desc_q.decouple  <= cfg_q[CfgDecoupleBit];
                desc_q.deburst   <= cfg_q[CfgDeburstBit];
            end
        end
    end

    dma_id_counter #(
        .Width    (IdCntWidth),
        .ResetVal (IdCntWidth'(1))
    ) u_next_id (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (handshake),
        .cnt_o (next_id)
    );

    dma_id_counter #(
        .Width    (IdCntWidth),
        .ResetVal ('0)
    ) u_done_id (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (done_acc),
        .cnt_o (done_id)
    );

    // combinational response is masked while reset is held
    assign reg_ready_o  = ready & ~rst_i;
    assign reg_error_o  = error & ~rst_i;
    assign reg_rdata_o  = rst_i ? '0 : rdata;
    assign desc_valid_o = state_q == ISSUE;
    assign desc_o       = desc_q;
    assign busy_o       = busy_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_dma_desc_frontend.sv
// Scoreboard bench for dma_desc_frontend: directed register
// accesses, descriptor launches, stalls, ID wrap and reset.
module tb_dma_desc_frontend;
    import dma_frontend_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_valid = 1'b0;
    logic        reg_write = 1'b0;
    logic [11:0] reg_addr = '0;
    logic [63:0] reg_wdata = '0;
    logic [7:0]  reg_wstrb = '0;
    logic        reg_ready;
    logic [63:0] reg_rdata;
    logic        reg_error;
    logic        desc_valid;
    logic        desc_ready = 1'b1;
    dma_desc_t   desc;
    logic        done = 1'b0;
    logic        busy;
    logic        irq;

    dma_desc_frontend dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_valid_i  (reg_valid),
        .reg_write_i  (reg_write),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_wstrb_i  (reg_wstrb),
        .reg_ready_o  (reg_ready),
        .reg_rdata_o  (reg_rdata),
        .reg_error_o  (reg_error),
        .desc_valid_o (desc_valid),
        .desc_ready_i (desc_ready),
        .desc_o       (desc),
        .done_i       (done),
        .busy_o       (busy),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t      exp_q[$];
    string     name_q[$];
    dma_desc_t dexp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;
    int dv_cnt   = 0;
    int irq0, dv0;

    exp_t      e;
    string     en;
    dma_desc_t de;
    dma_desc_t d1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // response and descriptor monitor
    always @(negedge clk) begin
        if (irq) irq_cnt++;
        if (desc_valid) dv_cnt++;
        if (!rst && reg_valid && reg_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h, required none",
                         reg_rdata);
            end else begin
                e  = exp_q.pop_front();
                en = name_q.pop_front();
                check({en, "_rdata"}, reg_rdata, e.rdata);
                check({en, "_err"}, 64'(reg_error), 64'(e.err));
            end
        end
        if (!rst && desc_valid && desc_ready) begin
            if (dexp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_desc: got src %h, required none",
                         desc.src);
            end else begin
                de = dexp_q.pop_front();
                check("desc_src", desc.src, de.src);
                check("desc_dst", desc.dst, de.dst);
                check("desc_nb", desc.num_bytes, de.num_bytes);
                check("desc_cfg", 64'({desc.decouple, desc.deburst}),
                      64'({de.decouple, de.deburst}));
            end
        end
    end

    task automatic access(input string name, input logic wr,
                          input logic [11:0] addr, input logic [63:0] wdata,
                          input logic [7:0] strb, input logic [63:0] xrd,
                          input logic xerr, input int xlat);
        int   cyc;
        exp_t tmp;
        string tn;
        cyc = 0;
        tmp.rdata = xrd;
        tmp.err   = xerr;
        exp_q.push_back(tmp);
        name_q.push_back(name);
        reg_valid = 1'b1;
        reg_write = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        reg_wstrb = strb;
        do begin
            @(negedge clk);
            cyc++;
        end while (!reg_ready && cyc < 50);
        if (!reg_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: ready low after %0d cycles, required high",
                     name, cyc);
            tmp = exp_q.pop_back();
            tn  = name_q.pop_back();
        end else if (xlat != 0) begin
            check({name, "_latency"}, 64'(cyc), 64'(xlat));
        end
        @(posedge clk);
        #1;
        reg_valid = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic wr(input string name, input logic [11:0] addr,
                      input logic [63:0] data, input logic [7:0] strb,
                      input logic xerr);
        access(name, 1'b1, addr, data, strb, 64'h0, xerr, 0);
    endtask

    task automatic rd(input string name, input logic [11:0] addr,
                      input logic [63:0] xrd, input logic xerr);
        access(name, 1'b0, addr, 64'h0, 8'h00, xrd, xerr, 0);
    endtask

    task automatic launch(input string name, input logic [63:0] id,
                          input int xlat);
        dexp_q.push_back(d1);
        access(name, 1'b0, RegNextId, 64'h0, 8'h00, id, 1'b0, xlat);
    endtask

    task automatic program_regs();
        wr("wr_src", RegSrc, 64'h8000_0000, 8'hFF, 1'b0);
        wr("wr_dst", RegDst, 64'h8000_1000, 8'hFF, 1'b0);
        wr("wr_nb", RegNumBytes, 64'h40, 8'hFF, 1'b0);
        wr("wr_cfg", RegConfig, 64'h1, 8'hFF, 1'b0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        reg_valid  = 1'b0;
        done       = 1'b0;
        desc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    initial begin
        d1.src       = 64'h8000_0000;
        d1.dst       = 64'h8000_1000;
        d1.num_bytes = 64'h40;
        d1.decouple  = 1'b1;
        d1.deburst   = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check("reset_ctl", 64'({reg_ready, reg_error, desc_valid, busy, irq}),
              64'h0);
        check("reset_rdata", reg_rdata, 64'h0);
        check("reset_desc", desc.src | desc.dst | desc.num_bytes, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // zero-length launch is refused
        dv0 = dv_cnt;
        rd("nb0_nextid", RegNextId, 64'h0, 1'b1);
        check("nb0_no_desc", 64'(dv_cnt), 64'(dv0));
        rd("done_id_rst", RegDoneId, 64'h0, 1'b0);
        program_regs();
        wr("dst_strb", RegDst, '1, 8'h02, 1'b0);
        rd("dst_strb_rb", RegDst, 64'h8000_FF00, 1'b0);
        wr("dst_fix", RegDst, 64'h8000_1000, 8'hFF, 1'b0);
        wr("cfg_all", RegConfig, '1, 8'hFF, 1'b0);
        rd("cfg_rb", RegConfig, 64'h3, 1'b0);
        wr("cfg_one", RegConfig, 64'h1, 8'hFF, 1'b0);
        rd("src_rb", RegSrc, 64'h8000_0000, 1'b0);

        launch("launch1", 64'h1, 2);
        launch("launch2", 64'h2, 2);
        rd("status_two", RegStatus, 64'h201, 1'b0);
        irq0 = irq_cnt;
        pulse_done();
        pulse_done();
        repeat (2) @(posedge clk);
        #1;
        check("irq_two", 64'(irq_cnt - irq0), 64'h2);
        rd("done_id_two", RegDoneId, 64'h2, 1'b0);
        rd("status_idle", RegStatus, 64'h0, 1'b0);

        // backpressure holds the descriptor
        do_reset();
        program_regs();
        desc_ready = 1'b0;
        fork
            launch("bp_launch", 64'h1, 0);
            begin
                int w;
                w = 0;
                while (!desc_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 5; i++) begin
                    check("hold_valid", 64'(desc_valid), 64'h1);
                    check("hold_src", desc.src, 64'h8000_0000);
                    check("hold_dst", desc.dst, 64'h8000_1000);
                    check("hold_ready", 64'(reg_ready), 64'h0);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                desc_ready = 1'b1;
            end
        join
        check("bp_busy", 64'(busy), 64'h1);
        rd("bp_status", RegStatus, 64'h101, 1'b0);

        // window full: NEXT_ID stalls until a completion
        launch("fill2", 64'h2, 2);
        launch("fill3", 64'h3, 2);
        launch("fill4", 64'h4, 2);
        rd("status_full", RegStatus, 64'h401, 1'b0);
        irq0 = irq_cnt;
        fork
            launch("full_launch", 64'h5, 0);
            begin
                repeat (6) @(negedge clk);
                check("full_stall_ready", 64'(reg_ready), 64'h0);
                check("full_no_desc", 64'(desc_valid), 64'h0);
                @(posedge clk);
                #1;
                done = 1'b1;
                @(posedge clk);
                #1;
                done = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("full_irq_once", 64'(irq_cnt - irq0), 64'h1);
        rd("full_done_id", RegDoneId, 64'h1, 1'b0);

        // stray completion, ID wrap, simultaneous launch and done
        do_reset();
        program_regs();
        irq0 = irq_cnt;
        pulse_done();
        repeat (2) @(posedge clk);
        #1;
        check("stray_no_irq", 64'(irq_cnt - irq0), 64'h0);
        rd("stray_done_id", RegDoneId, 64'h0, 1'b0);
        rd("stray_status", RegStatus, 64'h0, 1'b0);
        force dut.u_next_id.cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_next_id.cnt_q;
        launch("wrap_max", 64'hFFFF_FFFF, 2);
        launch("wrap_one", 64'h1, 2);
        irq0 = irq_cnt;
        fork
            launch("same_cycle", 64'h2, 2);
            begin
                int w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!desc_valid && w < 20);
                done = 1'b1;
                @(posedge clk);
                #1;
                done = 1'b0;
            end
        join
        rd("same_status", RegStatus, 64'h201, 1'b0);
        rd("same_done_id", RegDoneId, 64'h1, 1'b0);
        check("same_irq", 64'(irq_cnt - irq0), 64'h1);

        // error responses leave state untouched
        wr("err_wr_next", RegNextId, 64'h5, 8'hFF, 1'b1);
        wr("err_wr_status", RegStatus, 64'h5, 8'hFF, 1'b1);
        rd("err_rd_38", 12'h038, 64'h0, 1'b1);
        rd("err_rd_04", 12'h004, 64'h0, 1'b1);
        wr("err_wr_01", 12'h001, 64'hDEAD, 8'hFF, 1'b1);
        rd("err_src_keep", RegSrc, 64'h8000_0000, 1'b0);

        // reset in the middle of ISSUE
        desc_ready = 1'b0;
        reg_valid  = 1'b1;
        reg_write  = 1'b0;
        reg_addr   = RegNextId;
        begin
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!desc_valid && w < 20);
        end
        check("rst_pre_issue", 64'(desc_valid), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_ctl",
              64'({reg_ready, reg_error, desc_valid, busy, irq}), 64'h0);
        check("rst_mid_rdata", reg_rdata, 64'h0);
        check("rst_mid_desc", desc.src | desc.dst | desc.num_bytes, 64'h0);
        reg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        desc_ready = 1'b1;
        repeat (2) @(posedge clk);

        check("rsp_queue_empty", 64'(exp_q.size()), 64'h0);
        check("desc_queue_empty", 64'(dexp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

endmodule
